// File: rtl/int_ops_pkg.sv
// Shared types and helpers for the conf_int_* integer operator family.
// Widths here are the library defaults; the sign-extension helper is common.
package int_ops_pkg;

  localparam int OP_BITWIDTH_DEF        = 32;
  localparam int DATA_PATH_BITWIDTH_DEF = 32;

  // Widest data path any conf_int_* block may be built with.
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  // Keep the low w bits of v and replicate bit w-1 above them.
  // w must lie in 1..MAX_W; callers enforce that at elaboration.
  function automatic logic [MAX_W-1:0] sext(
    input logic [MAX_W-1:0] v,
    input int               w
  );
    logic [MAX_W-1:0] r;
    logic             sb;
    sb = v[IDX_W'(w - 1)];
    r  = v;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= w) r[i] = sb;
    end
    return r;
  endfunction

endpackage

// File: rtl/conf_int_add_noff_arch_agnos_operand_condition.sv
// Truncates each lane to OP_BITWIDTH bits and sign-extends it
// back to DATA_PATH_BITWIDTH. Purely combinational.
module operand_condition
  import int_ops_pkg::*;
#(
  parameter int OP_BITWIDTH        = OP_BITWIDTH_DEF,
  parameter int DATA_PATH_BITWIDTH = DATA_PATH_BITWIDTH_DEF,
  parameter int LANES              = 1
) (
  input  logic [LANES-1:0][DATA_PATH_BITWIDTH-1:0] d,
  output logic [LANES-1:0][DATA_PATH_BITWIDTH-1:0] q
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_W-1:0] ext;

    // Widen to the helper's width, truncate and sign-extend.
    always_comb begin
      ext = sext(MAX_W'(d[i]), OP_BITWIDTH);
    end

    assign q[i] = ext[DATA_PATH_BITWIDTH-1:0];

    // Bits above the data path are a by-product of the shared helper.
    if (DATA_PATH_BITWIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ext[MAX_W-1:DATA_PATH_BITWIDTH];
    end
  end

endmodule

// File: rtl/conf_int_add_noff_arch_agnos.sv
// Exact signed adder, no flip-flops; adder architecture is left to
// synthesis via the native '+'. clk/rst exist only for pin compatibility.
module conf_int_add_noff_arch_agnos
  import int_ops_pkg::*;
#(
  parameter int OP_BITWIDTH        = OP_BITWIDTH_DEF,
  parameter int DATA_PATH_BITWIDTH = DATA_PATH_BITWIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [DATA_PATH_BITWIDTH-1:0] c
);

  localparam int DW = DATA_PATH_BITWIDTH;

  if (OP_BITWIDTH < 1 || OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_bad_op
    $fatal(1, "OP_BITWIDTH must be in 1..DATA_PATH_BITWIDTH");
  end

  if (DATA_PATH_BITWIDTH > MAX_W) begin : g_bad_dp
    $fatal(1, "DATA_PATH_BITWIDTH exceeds the operator library limit");
  end

  logic [1:0][DW-1:0] ops_in;
  logic [1:0][DW-1:0] ops;
  logic [DW-1:0]      s;

  assign ops_in = {b, a};

  operand_condition #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DW),
    .LANES              (2)
  ) u_cond_in (
    .d (ops_in),
    .q (ops)
  );

  // The single adder; bits above OP_BITWIDTH-1 are rebuilt below.
  always_comb begin
    s = ops[0] + ops[1];
  end

  operand_condition #(
    .OP_BITWIDTH        (OP_BITWIDTH),
    .DATA_PATH_BITWIDTH (DW),
    .LANES              (1)
  ) u_cond_out (
    .d (s),
    .q (c)
  );

  // Clock and reset deliberately have no path to the sum.
  logic unused_ctl;
  assign unused_ctl = clk ^ rst;

endmodule

// File: tb/tb_conf_int_add_noff_arch_agnos.sv
// Directed bench for conf_int_add_noff_arch_agnos at 32/32 and 8/32.
// Both instances share operands; each result is checked separately.
module tb_conf_int_add_noff_arch_agnos;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic [31:0] c32;
  logic [31:0] c8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conf_int_add_noff_arch_agnos u_dut32 (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c32)
  );

  conf_int_add_noff_arch_agnos #(
    .OP_BITWIDTH        (8),
    .DATA_PATH_BITWIDTH (32)
  ) u_dut8 (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands just after an edge, sample one full period later.
  task automatic apply(input logic [31:0] va, input logic [31:0] vb);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref8(input logic [31:0] x,
                                       input logic [31:0] y);
    logic signed [7:0] t;
    t = x[7:0] + y[7:0];
    return 32'(t);
  endfunction

  initial begin
    @(posedge clk);
    #1;

    apply(32'd5, 32'd7);
    chk("d32_5p7", c32, 32'd12);
    chk("d8_5p7", c8, 32'h0000000C);

    apply(-32'sd5, -32'sd3);
    chk("d32_m5m3", c32, 32'hFFFFFFF8);
    chk("d8_m5m3", c8, 32'hFFFFFFF8);

    apply(32'h7FFFFFFF, 32'd1);
    chk("d32_maxp1", c32, 32'h80000000);
    chk("d8_maxp1", c8, 32'h00000000);

    apply(32'hFFFFFFFF, 32'd1);
    chk("d32_m1p1", c32, 32'h00000000);
    chk("d8_m1p1", c8, 32'h00000000);

    apply(32'h1234567F, 32'h00000001);
    chk("d32_hi_ign", c32, 32'h12345680);
    chk("d8_hi_ign", c8, 32'hFFFFFF80);

    apply(32'h10, 32'h20);
    chk("d32_10p20", c32, 32'h00000030);
    chk("d8_10p20", c8, 32'h00000030);

    apply(32'h80000000, 32'h80000000);
    chk("d32_minmin", c32, 32'h00000000);
    chk("d8_minmin", c8, 32'h00000000);

    apply(32'h000000FF, 32'h00000000);
    chk("d32_ff", c32, 32'h000000FF);
    chk("d8_ff", c8, 32'hFFFFFFFF);

    apply(32'h0000007F, 32'h00000000);
    chk("d8_7f", c8, 32'h0000007F);

    apply(32'h00000080, 32'h00000080);
    chk("d32_80p80", c32, 32'h00000100);
    chk("d8_80p80", c8, 32'h00000000);

    a = 32'd100;
    b = -32'sd250;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hi32", c32, 32'hFFFFFF6A);
      chk("rst_hi8", c8, 32'h0000006A);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rst_lo32", c32, 32'hFFFFFF6A);
      chk("rst_lo8", c8, 32'h0000006A);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hi2_32", c32, 32'hFFFFFF6A);
      chk("rst_hi2_8", c8, 32'h0000006A);
    end

    for (int i = 0; i < 500; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      rst = 1'($urandom_range(0, 1));
      apply(ra, rb);
      chk("rnd32", c32, 32'(ra + rb));
      chk("rnd8", c8, ref8(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
